// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  localparam int          MDU_STEPS = 32;
  localparam logic [31:0] DIV0_Q    = 32'hFFFFFFFF;
  localparam logic [31:0] INT_MIN   = 32'h80000000;

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration: shift-add for multiply, restoring trial-subtract for divide.
// acc holds {high, low}: product/multiplier for multiply, remainder/dividend-quotient for divide.
module mdu_step (
  input  logic        is_div,
  input  logic [63:0] acc,
  input  logic [31:0] opnd,
  output logic [63:0] acc_next
);

  logic [32:0] sum;
  logic [32:0] rem_shift;
  logic [31:0] sub;
  logic        ge;

  always_comb begin
    sum       = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    rem_shift = {acc[63:32], acc[31]};
    // The partial remainder never exceeds the divisor, so the 32-bit difference is exact when ge.
    ge        = rem_shift >= {1'b0, opnd};
    sub       = rem_shift[31:0] - opnd;
    if (is_div)
      acc_next = ge ? {sub, acc[30:0], 1'b1} : {rem_shift[31:0], acc[30:0], 1'b0};
    else
      acc_next = {sum, acc[31:1]};
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake.
// Define MDU_FAST_MUL_EN for a single-cycle 32x32 multiplier on the multiply ops.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wb_rd,
  output logic            wb_we
);

  mdu_state_t  state;
  mdu_op_t     op;
  logic [5:0]  cnt;
  logic [63:0] acc;
  logic [63:0] step_next;
  logic [31:0] opnd;
  logic [4:0]  rd_q;
  logic        neg_res;
  logic        neg_rem;
  logic        special;

  mdu_op_t     op_in;
  logic        in_div;
  logic        a_sgn;
  logic        b_sgn;
  logic        in_special;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] spec_val;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] fix_val;

  mdu_step u_step (
    .is_div   (op[2]),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (step_next)
  );

  // Magnitude conversion and special-case detection on the incoming operands.
  always_comb begin
    op_in      = mdu_op_t'(funct3);
    in_div     = funct3[2];
    a_sgn      = a[31] & (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    b_sgn      = b[31] & (op_in inside {OP_MULH, OP_DIV, OP_REM});
    a_mag      = a_sgn ? -a : a;
    b_mag      = b_sgn ? -b : b;
    in_special = 1'b0;
    spec_val   = '0;
    if (in_div && b == '0) begin
      in_special = 1'b1;
      spec_val   = funct3[1] ? a : DIV0_Q;
    end else if ((op_in == OP_DIV || op_in == OP_REM) && a == INT_MIN && b == DIV0_Q) begin
      in_special = 1'b1;
      spec_val   = funct3[1] ? 32'd0 : INT_MIN;
    end
  end

  always_comb begin
    prod    = neg_res ? -acc : acc;
    quo     = neg_res ? -acc[31:0] : acc[31:0];
    rem     = neg_rem ? -acc[63:32] : acc[63:32];
    fix_val = '0;
    if (special)
      fix_val = acc[31:0];
    else begin
      case (op)
        OP_MUL:                        fix_val = prod[31:0];
        OP_MULH, OP_MULHSU, OP_MULHU:  fix_val = prod[63:32];
        OP_DIV, OP_DIVU:               fix_val = quo;
        default:                       fix_val = rem;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      op      <= OP_MUL;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      rd_q    <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      special <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      wb_rd   <= '0;
      wb_we   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            op      <= op_in;
            rd_q    <= rd;
            neg_res <= a_sgn ^ b_sgn;
            neg_rem <= a_sgn;
            special <= in_special;
            cnt     <= '0;
            opnd    <= b_mag;
            if (in_special) begin
              acc   <= {32'd0, spec_val};
              state <= FIX;
            end
`ifdef MDU_FAST_MUL_EN
            else if (!in_div) begin
              acc   <= {32'd0, a_mag} * {32'd0, b_mag};
              state <= FIX;
            end
`endif
            else begin
              acc   <= {32'd0, a_mag};
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= step_next;
          cnt <= cnt + 6'd1;
          if (cnt == 6'(MDU_STEPS - 1))
            state <= FIX;
        end
        FIX: begin
          result <= fix_val;
          wb_rd  <= rd_q;
          wb_we  <= (rd_q != 5'd0);
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          wb_we <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed vector table, multi-cycle corner sequences, randomized ops vs model.
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic [2:0]  funct3  = 3'd0;
  logic [31:0] a       = '0;
  logic [31:0] b       = '0;
  logic [4:0]  rd      = '0;
  logic        busy;
  logic        done;
  logic        wb_we;
  logic [31:0] result;
  logic [4:0]  wb_rd;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  r;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [13];

  always #5 clk = ~clk;

  mdu_iter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .funct3  (funct3),
    .a       (a),
    .b       (b),
    .rd      (rd),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .wb_rd   (wb_rd),
    .wb_we   (wb_we)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic following the RV32M rules.
  function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint      sx;
    longint      sy;
    longint      ux;
    longint      uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    case (f)
      3'd0: begin p = 64'(ux * uy); return p[31:0]; end
      3'd1: begin p = 64'(sx * sy); return p[63:32]; end
      3'd2: begin p = 64'(sx * uy); return p[63:32]; end
      3'd3: begin p = 64'(ux * uy); return p[63:32]; end
      3'd4: begin
        if (y == 32'd0) return 32'hFFFFFFFF;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
        return 32'(sx / sy);
      end
      3'd5: begin
        if (y == 32'd0) return 32'hFFFFFFFF;
        return x / y;
      end
      3'd6: begin
        if (y == 32'd0) return x;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'd0;
        return 32'(sx % sy);
      end
      default: begin
        if (y == 32'd0) return x;
        return x % y;
      end
    endcase
  endfunction

  // Cycle, counted from the accept edge, whose closing edge sees done high.
  function automatic int expLat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (f[2] && y == 32'd0) return 2;
    if ((f == 3'd4 || f == 3'd6) && x == 32'h80000000 && y == 32'hFFFFFFFF) return 2;
`ifdef MDU_FAST_MUL_EN
    if (!f[2]) return 2;
`endif
    return 34;
  endfunction

  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                               input logic [4:0] r, output logic [31:0] res, output logic [4:0] wrd,
                               output logic we, output int lat, output logic busyOk, output logic holdOk);
    @(negedge clk);
    funct3 = f; a = x; b = y; rd = r; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; funct3 = 3'($urandom); a = $urandom; b = $urandom; rd = 5'($urandom);
    lat = 0; res = '0; wrd = '0; we = 1'b0; busyOk = 1'b1; holdOk = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (!busy) busyOk = 1'b0;
      if (done) begin
        lat = c; res = result; wrd = wb_rd; we = wb_we;
        break;
      end
    end
    @(negedge clk);
    if (busy || done) busyOk = 1'b0;
    holdOk = (result === res);
  endtask

  task automatic runAndCheck(input string tag, input logic [2:0] f, input logic [31:0] x,
                             input logic [31:0] y, input logic [4:0] r, input logic [31:0] exp);
    logic [31:0] res;
    logic [4:0]  wrd;
    logic        we;
    int          lat;
    logic        busyOk;
    logic        holdOk;
    applyStimulus(f, x, y, r, res, wrd, we, lat, busyOk, holdOk);
    checkOutput({tag, "_result"}, res, exp);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat(f, x, y)));
    checkOutput({tag, "_busy"}, {31'd0, busyOk}, 32'd1);
    checkOutput({tag, "_hold"}, {31'd0, holdOk}, 32'd1);
    checkOutput({tag, "_wb_rd"}, {27'd0, wrd}, {27'd0, r});
    checkOutput({tag, "_wb_we"}, {31'd0, we}, {31'd0, (r != 5'd0)});
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  r;
    logic [31:0] res;
    logic [4:0]  wrd;
    int          lat;
    int          extraDone;
    int          busyLow;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB};
    vecs[1]  = '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE};
    vecs[2]  = '{3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd7,  32'h00000000};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF,   32'd2,        5'd8,  32'hFFFFFFFF};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9,   32'd2,        5'd9,  32'hFFFFFFFD};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9,   32'd2,        5'd10, 32'hFFFFFFFF};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,        5'd11, 32'd14};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,        5'd12, 32'd2};
    vecs[8]  = '{3'd5, 32'd100,        32'd0,        5'd13, 32'hFFFFFFFF};
    vecs[9]  = '{3'd7, 32'd100,        32'd0,        5'd14, 32'd100};
    vecs[10] = '{3'd4, 32'h80000000,   32'hFFFFFFFF, 5'd15, 32'h80000000};
    vecs[11] = '{3'd6, 32'h80000000,   32'hFFFFFFFF, 5'd16, 32'd0};
    vecs[12] = '{3'd0, 32'd3,          32'd4,        5'd0,  32'd12};

    repeat (3) @(negedge clk);
    checkOutput("reset_busy",   {31'd0, busy},  32'd0);
    checkOutput("reset_done",   {31'd0, done},  32'd0);
    checkOutput("reset_result", result,         32'd0);
    checkOutput("reset_wb_rd",  {27'd0, wb_rd}, 32'd0);
    checkOutput("reset_wb_we",  {31'd0, wb_we}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++)
      runAndCheck($sformatf("vec%0d", i), vecs[i].f, vecs[i].x, vecs[i].y, vecs[i].r, vecs[i].exp);

    // Starts during CALC and during the done cycle must both be ignored.
    @(negedge clk);
    funct3 = 3'd5; a = 32'd100; b = 32'd7; rd = 5'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; res = '0; wrd = '0; busyLow = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 5) begin start = 1'b1; funct3 = 3'd7; a = 32'd5; b = 32'd0; rd = 5'd1; end
      if (c == 6) start = 1'b0;
      if (!busy) busyLow++;
      if (done) begin lat = c; res = result; wrd = wb_rd; break; end
    end
    start = 1'b1; funct3 = 3'd0; a = 32'd3; b = 32'd3; rd = 5'd2;
    @(negedge clk);
    start = 1'b0;
    checkOutput("ign_result",   res,              32'd14);
    checkOutput("ign_latency",  32'(lat),         32'd34);
    checkOutput("ign_wb_rd",    {27'd0, wrd},     32'd9);
    checkOutput("ign_busylow",  32'(busyLow),     32'd0);
    checkOutput("ign_donecyc",  {31'd0, busy},    32'd0);
    extraDone = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) extraDone++;
    end
    checkOutput("ign_nostart", 32'(extraDone), 32'd0);

    // Reset in the middle of CALC discards the operation.
    @(negedge clk);
    funct3 = 3'd5; a = 32'd100; b = 32'd7; rd = 5'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy",   {31'd0, busy},  32'd0);
    checkOutput("midrst_done",   {31'd0, done},  32'd0);
    checkOutput("midrst_result", result,         32'd0);
    checkOutput("midrst_wb_rd",  {27'd0, wb_rd}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    runAndCheck("postrst", 3'd7, 32'd100, 32'd7, 5'd4, 32'd2);

    for (int i = 0; i < 24; i++) begin
      f = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
        2: y = 32'($urandom_range(1, 20));
        3: x = 32'($urandom_range(0, 50));
        default: ;
      endcase
      r = 5'($urandom);
      runAndCheck($sformatf("rnd%0d", i), f, x, y, r, refModel(f, x, y));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
